// File: rtl/write_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : write_burst_ctrl_if
// Description : Command, write-data and DQ output bundle for the DDR5 PHY
//               write burst controller. The slave modport is the controller
//               side; the master modport is whatever feeds it commands and data.
// Signals     : wr_cmd_valid_i/wr_cmd_ready_o  command handshake
//               write_crc_en_i, phy_crc_mode_i,
//               seamless_i, bl_i                command configuration
//               wr_data_i / wr_data_req_o       write data pair and consume
//               crc_i                           CRC beat pair
//               dq_o, dq_oe_o, crc_beat_o       registered DQ outputs
//               burst_done_o, cmd_err_o         status pulses
// Revision    : 1.0 - initial release
// ============================================================================
interface write_burst_ctrl_if #(
    parameter int DQ_W = 8
);
    logic                wr_cmd_valid_i;
    logic                wr_cmd_ready_o;
    logic                write_crc_en_i;
    logic                phy_crc_mode_i;
    logic                seamless_i;
    logic [1:0]          bl_i;
    logic [2*DQ_W-1:0]   wr_data_i;
    logic [2*DQ_W-1:0]   crc_i;
    logic                wr_data_req_o;
    logic [2*DQ_W-1:0]   dq_o;
    logic                dq_oe_o;
    logic                crc_beat_o;
    logic                burst_done_o;
    logic                cmd_err_o;

    modport slave (
        input  wr_cmd_valid_i, write_crc_en_i, phy_crc_mode_i, seamless_i,
               bl_i, wr_data_i, crc_i,
        output wr_cmd_ready_o, wr_data_req_o, dq_o, dq_oe_o, crc_beat_o,
               burst_done_o, cmd_err_o
    );

    modport master (
        output wr_cmd_valid_i, write_crc_en_i, phy_crc_mode_i, seamless_i,
               bl_i, wr_data_i, crc_i,
        input  wr_cmd_ready_o, wr_data_req_o, dq_o, dq_oe_o, crc_beat_o,
               burst_done_o, cmd_err_o
    );
endinterface
`default_nettype wire

// File: rtl/write_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : write_burst_ctrl
// Description : Write-path burst controller. Accepts one write command per
//               burst and runs a counted window of DATA, optional PAD and
//               optional CRC cycles, driving registered DQ data and enable.
// Ports       : clk_i  - PHY clock
//               rst_i  - asynchronous active-high reset
//               bus    - write_burst_ctrl_if.slave (command, data, DQ outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module write_burst_ctrl #(
    parameter int DQ_W = 8
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    write_burst_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAD  = 2'd2,
        S_CRC  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [4:0]         r_cnt;
    logic [4:0]         w_cnt_nxt;
    logic               r_pad_en;
    logic               r_crc_en;
    logic               r_cmd_err;
    logic               r_dq_oe;
    logic               r_crc_beat;
    logic [2*DQ_W-1:0]  r_dq;

    logic               w_last;
    logic               w_ready;
    logic               w_accept;
    logic               w_start;
    logic               w_add_crc;
    logic               w_bl16;
    logic               w_new_pad;
    logic               w_new_crc;
    logic [4:0]         w_new_cnt;

    // Final window cycle: the CRC cycle, or the last DATA cycle of a burst
    // that has neither pad nor CRC. Depends on state only, so ready has no
    // combinational path from the command inputs.
    assign w_last   = (r_state == S_CRC) ||
                      ((r_state == S_DATA) && (r_cnt == 5'd0) && !r_pad_en && !r_crc_en);
    assign w_ready  = (r_state == S_IDLE) || w_last;
    assign w_accept = bus.wr_cmd_valid_i && w_ready;
    assign w_start  = w_accept && (bus.bl_i != 2'b11);

    // Configuration decode for the command being offered this cycle.
    assign w_add_crc = bus.write_crc_en_i && !bus.phy_crc_mode_i;
    assign w_bl16    = (bus.bl_i != 2'b00);
    assign w_new_pad = !w_bl16 && w_add_crc;
    // Seamless BL16 fills the whole window with data, so no CRC cycle.
    assign w_new_crc = w_add_crc && !(w_bl16 && bus.seamless_i);
    // Counter holds remaining cycles minus one.
    assign w_new_cnt = !w_bl16 ? 5'd3 : (bus.seamless_i ? 5'd15 : 5'd7);

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next    = S_DATA;
                    w_cnt_nxt = w_new_cnt;
                end
            end
            S_DATA: begin
                if (r_cnt != 5'd0) begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end else if (r_pad_en) begin
                    w_next    = S_PAD;
                    w_cnt_nxt = 5'd3;
                end else if (r_crc_en) begin
                    w_next    = S_CRC;
                    w_cnt_nxt = 5'd0;
                end
            end
            S_PAD: begin
                if (r_cnt != 5'd0) begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end else begin
                    w_next    = S_CRC;
                    w_cnt_nxt = 5'd0;
                end
            end
            default: begin
            end
        endcase
        // End of window chains straight into the next burst when one is taken.
        if (w_last) begin
            if (w_start) begin
                w_next    = S_DATA;
                w_cnt_nxt = w_new_cnt;
            end else begin
                w_next    = S_IDLE;
                w_cnt_nxt = 5'd0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pad_en <= 1'b0;
            r_crc_en <= 1'b0;
        end else if (w_start) begin
            r_pad_en <= w_new_pad;
            r_crc_en <= w_new_crc;
        end
    end

    // DQ mux registered one cycle behind the state that selects it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dq       <= '0;
            r_dq_oe    <= 1'b0;
            r_crc_beat <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            case (r_state)
                S_DATA:  r_dq <= bus.wr_data_i;
                S_PAD:   r_dq <= '1;
                S_CRC:   r_dq <= bus.crc_i;
                default: r_dq <= '0;
            endcase
            r_dq_oe    <= (r_state != S_IDLE);
            r_crc_beat <= (r_state == S_CRC);
            r_cmd_err  <= w_accept && (bus.bl_i == 2'b11);
        end
    end

    assign bus.wr_cmd_ready_o = w_ready;
    assign bus.wr_data_req_o  = (r_state == S_DATA);
    assign bus.burst_done_o   = w_last;
    assign bus.dq_o           = r_dq;
    assign bus.dq_oe_o        = r_dq_oe;
    assign bus.crc_beat_o     = r_crc_beat;
    assign bus.cmd_err_o      = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_write_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_burst_ctrl
// Description : Directed bench for write_burst_ctrl. Each command pushes its
//               expected DQ beats into a scoreboard queue keyed by output cycle
//               and marks expected req/done/err/busy cycles; every cycle the
//               DUT outputs are compared against those expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_burst_ctrl;
    localparam int DQ_W = 8;
    localparam int MAXC = 400;

    typedef struct {
        int          t;
        logic [15:0] dq;
        logic        crc;
    } sb_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    sb_t  sb[$];
    bit   exp_req  [0:MAXC-1];
    bit   exp_done [0:MAXC-1];
    bit   exp_err  [0:MAXC-1];
    bit   exp_busy [0:MAXC-1];

    write_burst_ctrl_if #(.DQ_W(DQ_W)) bus ();

    write_burst_ctrl #(.DQ_W(DQ_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] dfun(int k);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'(k);
        hi = 8'(k * 7 + 3);
        return {hi, lo};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_exp(int from);
        sb.delete();
        for (int k = from; k < MAXC; k++) begin
            exp_req[k]  = 1'b0;
            exp_done[k] = 1'b0;
            exp_err[k]  = 1'b0;
            exp_busy[k] = 1'b0;
        end
    endtask

    // Model of one accepted command in cycle t.
    task automatic push_cmd(int t, logic [1:0] bl, logic seam, logic crcen,
                            logic mode, logic [15:0] crcv);
        int  nd;
        int  npad;
        int  ncrc;
        int  k;
        bit  add;
        if (bl == 2'b11) begin
            exp_err[t+1] = 1'b1;
            return;
        end
        add = crcen && !mode;
        if (bl == 2'b00) begin
            nd = 4; npad = add ? 4 : 0; ncrc = add ? 1 : 0;
        end else if (seam) begin
            nd = 16; npad = 0; ncrc = 0;
        end else begin
            nd = 8; npad = 0; ncrc = add ? 1 : 0;
        end
        k = t;
        for (int i = 0; i < nd; i++) begin
            k++;
            exp_req[k] = 1'b1; exp_busy[k] = 1'b1;
            sb.push_back('{k + 1, dfun(k), 1'b0});
        end
        for (int i = 0; i < npad; i++) begin
            k++;
            exp_busy[k] = 1'b1;
            sb.push_back('{k + 1, 16'hFFFF, 1'b0});
        end
        for (int i = 0; i < ncrc; i++) begin
            k++;
            exp_busy[k] = 1'b1;
            sb.push_back('{k + 1, crcv, 1'b1});
        end
        exp_done[k] = 1'b1;
    endtask

    task automatic step();
        sb_t e;
        @(posedge clk);
        cyc++;
        #1;
        bus.wr_data_i = dfun(cyc);
        chk("req",   32'(bus.wr_data_req_o),  32'(exp_req[cyc]));
        chk("done",  32'(bus.burst_done_o),   32'(exp_done[cyc]));
        chk("err",   32'(bus.cmd_err_o),      32'(exp_err[cyc]));
        chk("ready", 32'(bus.wr_cmd_ready_o), 32'(!exp_busy[cyc] || exp_done[cyc]));
        if (sb.size() != 0 && sb[0].t == cyc) begin
            e = sb.pop_front();
            chk("dq_oe", 32'(bus.dq_oe_o),    32'd1);
            chk("dq",    32'(bus.dq_o),       32'(e.dq));
            chk("crc",   32'(bus.crc_beat_o), 32'(e.crc));
        end else begin
            chk("dq_oe_idle", 32'(bus.dq_oe_o),    32'd0);
            chk("dq_idle",    32'(bus.dq_o),       32'd0);
            chk("crc_idle",   32'(bus.crc_beat_o), 32'd0);
        end
    endtask

    task automatic drive_cmd(logic [1:0] bl, logic seam, logic crcen, logic mode);
        bus.wr_cmd_valid_i = 1'b1;
        bus.bl_i           = bl;
        bus.seamless_i     = seam;
        bus.write_crc_en_i = crcen;
        bus.phy_crc_mode_i = mode;
    endtask

    // Drop valid and scramble configuration to show it was latched at accept.
    task automatic drop_cmd();
        bus.wr_cmd_valid_i = 1'b0;
        bus.bl_i           = 2'b01;
        bus.seamless_i     = 1'b1;
        bus.write_crc_en_i = 1'b1;
        bus.phy_crc_mode_i = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        clear_exp(0);
        rst                = 1'b1;
        bus.wr_cmd_valid_i = 1'b0;
        bus.bl_i           = 2'b00;
        bus.seamless_i     = 1'b0;
        bus.write_crc_en_i = 1'b0;
        bus.phy_crc_mode_i = 1'b0;
        bus.wr_data_i      = dfun(0);
        bus.crc_i          = 16'hA5C3;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dq",    32'(bus.dq_o),          32'd0);
        chk("rst_oe",    32'(bus.dq_oe_o),       32'd0);
        chk("rst_req",   32'(bus.wr_data_req_o), 32'd0);
        chk("rst_done",  32'(bus.burst_done_o),  32'd0);
        chk("rst_err",   32'(bus.cmd_err_o),     32'd0);
        chk("rst_crcb",  32'(bus.crc_beat_o),    32'd0);
        rst = 1'b0;
        step();

        // BL8, no CRC
        drive_cmd(2'b00, 1'b0, 1'b0, 1'b0);
        push_cmd(cyc, 2'b00, 1'b0, 1'b0, 1'b0, bus.crc_i);
        step();
        drop_cmd();
        repeat (6) step();

        // BL8 with PHY-appended CRC: 4 data, 4 pad, 1 CRC
        drive_cmd(2'b00, 1'b0, 1'b1, 1'b0);
        push_cmd(cyc, 2'b00, 1'b0, 1'b1, 1'b0, bus.crc_i);
        step();
        drop_cmd();
        repeat (12) step();

        // BL8 with CRC handled upstream: plain 4-cycle window
        drive_cmd(2'b10, 1'b0, 1'b1, 1'b1);
        bus.bl_i = 2'b00;
        push_cmd(cyc, 2'b00, 1'b0, 1'b1, 1'b1, bus.crc_i);
        step();
        drop_cmd();
        repeat (6) step();

        // BL16 seamless with CRC enabled: 16 data, no CRC cycle
        drive_cmd(2'b01, 1'b1, 1'b1, 1'b0);
        push_cmd(cyc, 2'b01, 1'b1, 1'b1, 1'b0, bus.crc_i);
        step();
        drop_cmd();
        repeat (19) step();

        // BL16 non-seamless with CRC: 8 data + 1 CRC
        bus.crc_i = 16'h3C96;
        drive_cmd(2'b10, 1'b0, 1'b1, 1'b0);
        push_cmd(cyc, 2'b10, 1'b0, 1'b1, 1'b0, bus.crc_i);
        step();
        drop_cmd();
        repeat (12) step();

        // Back-to-back BL16, second command held valid until taken at T+8
        drive_cmd(2'b01, 1'b0, 1'b0, 1'b0);
        push_cmd(cyc, 2'b01, 1'b0, 1'b0, 1'b0, bus.crc_i);
        for (int j = 0; j < 8; j++) step();
        push_cmd(cyc, 2'b01, 1'b0, 1'b0, 1'b0, bus.crc_i);
        step();
        drop_cmd();
        repeat (12) step();

        // Illegal burst length
        drive_cmd(2'b11, 1'b0, 1'b0, 1'b0);
        push_cmd(cyc, 2'b11, 1'b0, 1'b0, 1'b0, bus.crc_i);
        step();
        drop_cmd();
        repeat (4) step();

        // Asynchronous reset at DATA cycle 3 of BL16
        drive_cmd(2'b01, 1'b0, 1'b0, 1'b0);
        push_cmd(cyc, 2'b01, 1'b0, 1'b0, 1'b0, bus.crc_i);
        step();
        drop_cmd();
        bus.wr_cmd_valid_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("arst_oe",   32'(bus.dq_oe_o),       32'd0);
        chk("arst_dq",   32'(bus.dq_o),          32'd0);
        chk("arst_req",  32'(bus.wr_data_req_o), 32'd0);
        chk("arst_done", 32'(bus.burst_done_o),  32'd0);
        clear_exp(cyc);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Normal BL8 after reset release
        drive_cmd(2'b00, 1'b0, 1'b0, 1'b0);
        push_cmd(cyc, 2'b00, 1'b0, 1'b0, 1'b0, bus.crc_i);
        step();
        drop_cmd();
        repeat (7) step();

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
